// File: rtl/risc_decode_stage_if.sv
// Fetch/execute/writeback signal bundle for the RiSC-16 decode stage.
// The stage uses the slave modport; its environment uses master.
interface risc_decode_stage_if;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_op;
  logic [2:0]  id_wreg;
  logic        id_we;
  logic [15:0] id_imm;
  logic [15:0] id_pc;
  logic        wb_we;
  logic [2:0]  wb_reg;
  logic        ex_flush;

  modport slave (
    input  if_valid, if_instr, if_pc,
    input  id_ready, wb_we, wb_reg, ex_flush,
    output if_ready, read_reg1, read_reg2,
    output id_valid, id_op, id_wreg, id_we,
    output id_imm, id_pc
  );

  modport master (
    output if_valid, if_instr, if_pc,
    output id_ready, wb_we, wb_reg, ex_flush,
    input  if_ready, read_reg1, read_reg2,
    input  id_valid, id_op, id_wreg, id_we,
    input  id_imm, id_pc
  );
endinterface

// File: rtl/risc_decode_stage.sv
// RiSC-16 single-entry decode stage with register scoreboard.
// Optional RISC_WAW_CHECK_EN also stalls on a pending destination.
module risc_decode_stage (
  input  logic               clk,
  input  logic               reset,
  risc_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  op;
    logic [2:0]  wreg;
    logic        we;
    logic [15:0] imm;
    logic [15:0] pc;
  } id_ex_t;

  id_ex_t      q;
  id_ex_t      d;
  logic        full;
  logic [7:0]  pending;
  logic [7:0]  pend_d;
  logic        src_hz;
  logic        waw_hz;
  logic        hazard;
  logic        handoff;
  logic        capture;
  logic        valid;
  logic        ready;

  logic [2:0]  op;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic [15:0] sext7;

  assign op    = bus.if_instr[15:13];
  assign ra    = bus.if_instr[12:10];
  assign rb    = bus.if_instr[9:7];
  assign rc    = bus.if_instr[2:0];
  assign sext7 = {{9{bus.if_instr[6]}},
                  bus.if_instr[6:0]};

  // Decode the incoming word into the id/ex bundle.
  always_comb begin
    d      = '0;
    d.op   = op;
    d.wreg = ra;
    d.pc   = bus.if_pc;
    unique case (1'b1)
      (op == 3'b000) || (op == 3'b010): begin
        d.r1 = rb;
        d.r2 = rc;
        d.we = 1'b1;
      end
      op == 3'b001: begin
        d.r1  = rb;
        d.we  = 1'b1;
        d.imm = sext7;
      end
      op == 3'b011: begin
        d.we  = 1'b1;
        d.imm = {bus.if_instr[9:0], 6'b0};
      end
      op == 3'b100: begin
        d.r1  = rb;
        d.r2  = ra;
        d.imm = sext7;
      end
      op == 3'b101: begin
        d.r1  = rb;
        d.we  = 1'b1;
        d.imm = sext7;
      end
      op == 3'b110: begin
        d.r1  = ra;
        d.r2  = rb;
        d.imm = sext7;
      end
      op == 3'b111: begin
        d.r1 = rb;
        d.we = 1'b1;
      end
      default: ;
    endcase
    if (ra == 3'd0)
      d.we = 1'b0;
  end

  assign src_hz = pending[q.r1] | pending[q.r2];

`ifdef RISC_WAW_CHECK_EN
  assign waw_hz = q.we & pending[q.wreg];
`else
  assign waw_hz = 1'b0;
`endif

  assign hazard  = full & (src_hz | waw_hz);
  assign valid   = full & ~hazard & ~bus.ex_flush;
  assign handoff = valid & bus.id_ready;
  assign ready   = ~bus.ex_flush & (~full | handoff);
  assign capture = bus.if_valid & ready;

  // Scoreboard next state; an issuing write beats a same-register retire.
  always_comb begin
    pend_d = pending;
    if (bus.wb_we)
      pend_d[bus.wb_reg] = 1'b0;
    if (handoff && q.we)
      pend_d[q.wreg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Occupancy, scoreboard and held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 1'b0;
      pending <= '0;
      q       <= '0;
    end else begin
      pending <= pend_d;
      if (bus.ex_flush)
        full <= 1'b0;
      else if (capture)
        full <= 1'b1;
      else if (handoff)
        full <= 1'b0;
      if (capture)
        q <= d;
    end
  end

  assign bus.if_ready  = ready;
  assign bus.id_valid  = valid;
  assign bus.read_reg1 = q.r1;
  assign bus.read_reg2 = q.r2;
  assign bus.id_op     = q.op;
  assign bus.id_wreg   = q.wreg;
  assign bus.id_we     = q.we;
  assign bus.id_imm    = q.imm;
  assign bus.id_pc     = q.pc;

endmodule

// File: tb/tb_risc_decode_stage.sv
// Directed self-checking bench for risc_decode_stage.
// Expected values are hand-decoded from the RiSC-16 encodings.
module tb_risc_decode_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  risc_decode_stage_if bus();

  risc_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid = 1'b0;
    bus.if_instr = 16'h0;
    bus.if_pc    = 16'h0;
    bus.id_ready = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_reg   = 3'd0;
    bus.ex_flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic present(input logic [15:0] ins,
                         input logic [15:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_if_ready got %b exp 1", bus.if_ready);
    end
    checks++;
    if (bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_id_valid got %b exp 0", bus.id_valid);
    end
    checks++;
    if ({bus.read_reg1, bus.read_reg2, bus.id_op, bus.id_wreg,
         bus.id_we, bus.id_imm, bus.id_pc} !== 45'd0) begin
      errors++;
      $display("FAIL rst_outputs got r1=%0d r2=%0d op=%0d wr=%0d we=%b imm=%h pc=%h exp all 0",
               bus.read_reg1, bus.read_reg2, bus.id_op, bus.id_wreg,
               bus.id_we, bus.id_imm, bus.id_pc);
    end
    checks++;
    if (dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL rst_pending got %h exp 00", dut.pending);
    end
  endtask

  task automatic test_addi();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'h2C7F, 16'h0010);
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0010) begin
      errors++;
      $display("FAIL addi_valid_pc got v=%b pc=%h exp v=1 pc=0010",
               bus.id_valid, bus.id_pc);
    end
    checks++;
    if (bus.read_reg1 !== 3'd0 || bus.read_reg2 !== 3'd0 ||
        bus.id_wreg !== 3'd3 || bus.id_we !== 1'b1 ||
        bus.id_op !== 3'd1) begin
      errors++;
      $display("FAIL addi_fields got r1=%0d r2=%0d wr=%0d we=%b op=%0d exp 0 0 3 1 1",
               bus.read_reg1, bus.read_reg2, bus.id_wreg, bus.id_we,
               bus.id_op);
    end
    checks++;
    if (bus.id_imm !== 16'hFFFF) begin
      errors++;
      $display("FAIL addi_imm got %h exp FFFF", bus.id_imm);
    end
    tick();
    checks++;
    if (dut.pending !== 8'h08 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_issue got pend=%h v=%b exp pend=08 v=0",
               dut.pending, bus.id_valid);
    end
  endtask

  task automatic test_lui();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'h73FF, 16'h0012);
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_imm !== 16'hFFC0 || bus.id_wreg !== 3'd4 ||
        bus.read_reg1 !== 3'd0 || bus.read_reg2 !== 3'd0 ||
        bus.id_we !== 1'b1) begin
      errors++;
      $display("FAIL lui got imm=%h wr=%0d r1=%0d r2=%0d we=%b exp FFC0 4 0 0 1",
               bus.id_imm, bus.id_wreg, bus.read_reg1,
               bus.read_reg2, bus.id_we);
    end
  endtask

  task automatic test_r0_dest();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'h2001, 16'h0014);
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_we !== 1'b0 || bus.id_wreg !== 3'd0 ||
        bus.id_imm !== 16'h0001) begin
      errors++;
      $display("FAIL r0_dest got we=%b wr=%0d imm=%h exp 0 0 0001",
               bus.id_we, bus.id_wreg, bus.id_imm);
    end
    tick();
    checks++;
    if (dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL r0_pending got %h exp 00", dut.pending);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'hA400, 16'h0020);
    tick();
    present(16'h0880, 16'h0022);
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_lw_offer got v=%b rdy=%b exp 1 1",
               bus.id_valid, bus.if_ready);
    end
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0 ||
        dut.pending !== 8'h02) begin
      errors++;
      $display("FAIL lu_stall got v=%b rdy=%b pend=%h exp 0 0 02",
               bus.id_valid, bus.if_ready, dut.pending);
    end
    tick();
    bus.wb_we  = 1'b1;
    bus.wb_reg = 3'd1;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.read_reg1 !== 3'd1 ||
        bus.id_pc !== 16'h0022) begin
      errors++;
      $display("FAIL lu_no_bypass got v=%b r1=%0d pc=%h exp 0 1 0022",
               bus.id_valid, bus.read_reg1, bus.id_pc);
    end
    tick();
    bus.wb_we = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.read_reg1 !== 3'd1 ||
        bus.read_reg2 !== 3'd0 || bus.id_wreg !== 3'd2) begin
      errors++;
      $display("FAIL lu_wakeup got v=%b r1=%0d r2=%0d wr=%0d exp 1 1 0 2",
               bus.id_valid, bus.read_reg1, bus.read_reg2,
               bus.id_wreg);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    present(16'h8A85, 16'h0030);
    tick();
    present(16'hC881, 16'h0032);
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.if_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_hs got v=%b rdy=%b exp 1 0",
               bus.id_valid, bus.if_ready);
    end
    tick();
    checks++;
    if (bus.id_pc !== 16'h0030 || bus.read_reg1 !== 3'd5 ||
        bus.read_reg2 !== 3'd2 || bus.id_we !== 1'b0 ||
        bus.id_imm !== 16'h0005 || bus.id_op !== 3'd4) begin
      errors++;
      $display("FAIL stall_sw got pc=%h r1=%0d r2=%0d we=%b imm=%h op=%0d exp 0030 5 2 0 0005 4",
               bus.id_pc, bus.read_reg1, bus.read_reg2, bus.id_we,
               bus.id_imm, bus.id_op);
    end
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got rdy=%b exp 1", bus.if_ready);
    end
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_pc !== 16'h0032 || bus.read_reg1 !== 3'd2 ||
        bus.read_reg2 !== 3'd1 || bus.id_op !== 3'd6 ||
        bus.id_imm !== 16'h0001 || bus.id_we !== 1'b0 ||
        bus.id_valid !== 1'b1) begin
      errors++;
      $display("FAIL beq got pc=%h r1=%0d r2=%0d op=%0d imm=%h we=%b v=%b exp 0032 2 1 6 0001 0 1",
               bus.id_pc, bus.read_reg1, bus.read_reg2, bus.id_op,
               bus.id_imm, bus.id_we, bus.id_valid);
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL stall_drain got v=%b pend=%h exp 0 00",
               bus.id_valid, dut.pending);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins [4];
    logic [2:0]  wr  [4];
    ins = '{16'h2405, 16'h2806, 16'h3407, 16'h3808};
    wr  = '{3'd1, 3'd2, 3'd5, 3'd6};
    do_reset();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4)
        present(ins[i], 16'h0040 + 16'(2 * i));
      else
        bus.if_valid = 1'b0;
      #1;
      if (i < 4) begin
        checks++;
        if (bus.if_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.if_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if (bus.id_valid !== 1'b1 ||
            bus.id_pc !== 16'h0040 + 16'(2 * (i - 1)) ||
            bus.id_wreg !== wr[i-1]) begin
          errors++;
          $display("FAIL b2b_issue[%0d] got v=%b pc=%h wr=%0d exp 1 %h %0d",
                   i, bus.id_valid, bus.id_pc, bus.id_wreg,
                   16'h0040 + 16'(2 * (i - 1)), wr[i-1]);
        end
      end
      tick();
    end
    checks++;
    if (bus.id_valid !== 1'b0 || dut.pending !== 8'h66) begin
      errors++;
      $display("FAIL b2b_end got v=%b pend=%h exp 0 66",
               bus.id_valid, dut.pending);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'h3407, 16'h0060);
    tick();
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_reg   = 3'd5;
    tick();
    checks++;
    if (dut.pending !== 8'h20) begin
      errors++;
      $display("FAIL set_wins got %h exp 20", dut.pending);
    end
    tick();
    bus.wb_we = 1'b0;
    checks++;
    if (dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL wb_clear got %h exp 00", dut.pending);
    end
  endtask

  task automatic test_flush();
    do_reset();
    present(16'h2405, 16'h0050);
    tick();
    bus.ex_flush = 1'b1;
    present(16'h0880, 16'h0052);
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got v=%b rdy=%b exp 0 0",
               bus.id_valid, bus.if_ready);
    end
    tick();
    bus.ex_flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 ||
        dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL flush_after got v=%b rdy=%b pend=%h exp 0 1 00",
               bus.id_valid, bus.if_ready, dut.pending);
    end
    tick();
    checks++;
    if (dut.pending !== 8'h00 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_set got pend=%h v=%b exp 00 0",
               dut.pending, bus.id_valid);
    end
  endtask

  task automatic test_waw();
    logic exp_v;
`ifdef RISC_WAW_CHECK_EN
    exp_v = 1'b0;
`else
    exp_v = 1'b1;
`endif
    do_reset();
    bus.id_ready = 1'b1;
    present(16'h2405, 16'h0070);
    tick();
    present(16'hA400, 16'h0072);
    tick();
    bus.if_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== exp_v || bus.id_pc !== 16'h0072) begin
      errors++;
      $display("FAIL waw_issue got v=%b pc=%h exp %b 0072",
               bus.id_valid, bus.id_pc, exp_v);
    end
    if (!exp_v) begin
      bus.wb_we  = 1'b1;
      bus.wb_reg = 3'd1;
      tick();
      bus.wb_we = 1'b0;
      #1;
      checks++;
      if (bus.id_valid !== 1'b1) begin
        errors++;
        $display("FAIL waw_wakeup got v=%b exp 1", bus.id_valid);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.id_ready = 1'b1;
    present(16'hA400, 16'h0080);
    tick();
    present(16'h0880, 16'h0082);
    tick();
    bus.if_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 ||
        dut.pending !== 8'h00 || bus.read_reg1 !== 3'd0 ||
        bus.id_pc !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid got v=%b rdy=%b pend=%h r1=%0d pc=%h exp 0 1 00 0 0000",
               bus.id_valid, bus.if_ready, dut.pending,
               bus.read_reg1, bus.id_pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_addi();
    test_lui();
    test_r0_dest();
    test_load_use();
    test_stall();
    test_back_to_back();
    test_set_wins();
    test_flush();
    test_waw();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_decode_stage.md
# risc_decode_stage

Single-entry decode stage for the RiSC-16 pipeline, sitting between instruction fetch and the 8×16 register file.
- Captures one fetched instruction and decodes it into register-file read addresses, destination, opcode and a 16-bit immediate.
- Holds the instruction back while a scoreboard shows a source register still awaiting writeback.
- Drives the register file's combinational read ports directly, so the execute stage sees operands in the same cycle it accepts the instruction.

## Interface
Parameters:
- none (ISA-fixed widths: 16-bit instruction/PC, 3-bit register index)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where sampled high
- if_valid  in  1  fetch presents an instruction
- if_instr  in  16  instruction word
- if_pc  in  16  PC of if_instr
- if_ready  out  1  stage accepts if_instr this cycle
- read_reg1  out  3  register-file port-1 address; 0 if unused
- read_reg2  out  3  register-file port-2 address; 0 if unused
- id_valid  out  1  decoded instruction offered to execute
- id_ready  in  1  execute accepts this cycle
- id_op  out  3  opcode [15:13]
- id_wreg  out  3  destination register
- id_we  out  1  instruction writes id_wreg (never 1 when id_wreg=0)
- id_imm  out  16  decoded immediate
- id_pc  out  16  PC of held instruction
- wb_we  in  1  writeback retiring a register write this cycle
- wb_reg  in  3  register being written back
- ex_flush  in  1  squash held instruction and incoming fetch

## Operation
- Fields: rA=[12:10], rB=[9:7], rC=[2:0], imm7=[6:0], imm10=[9:0].
- Decode, performed at capture and stored in the output register:
  - add/nand (000/010): r1=rB, r2=rC, we=1, imm=0.
  - addi (001): r1=rB, r2=0, we=1, imm=sext(imm7).
  - lui (011): r1=0, r2=0, we=1, imm={imm10,6'b0}.
  - sw (100): r1=rB, r2=rA, we=0, imm=sext(imm7).
  - lw (101): r1=rB, r2=0, we=1, imm=sext(imm7).
  - beq (110): r1=rA, r2=rB, we=0, imm=sext(imm7).
  - jalr (111): r1=rB, r2=0, we=1, imm=0.
  - id_we is additionally forced to 0 when rA=0.
- State:
  - full bit: held instruction valid.
  - pending[7:0] scoreboard; bit 0 is hardwired to 0.
- Hazard (combinational, from registered state only; no same-cycle wb bypass):
  - full && (pending[read_reg1] || pending[read_reg2]).
- Handshakes:
  - id_valid = full && !hazard && !ex_flush.
  - Handoff = id_valid && id_ready.
  - if_ready = !ex_flush && (!full || handoff).
  - Capture = if_valid && if_ready.
- full next state:
  - Cleared by ex_flush.
  - Else set on capture.
  - Else cleared on handoff.
  - Else held.
- Scoreboard:
  - On handoff with id_we, set pending[id_wreg].
  - On wb_we, clear pending[wb_reg].
  - Same register set and cleared in one cycle → set wins.
- Flush:
  - Discards the held instruction and any if_instr offered that cycle.
  - Does not alter pending (squashed instructions never set bits).

## Timing
- Reset: full=0, pending=0, id_valid=0, if_ready=1 in the following cycle.
- Reset: read_reg1/2, id_op, id_wreg, id_we, id_imm, id_pc = 0.
- Latency: capture at edge N → id_valid high from cycle N+1 if no hazard.
- Throughput: one instruction/cycle with id_ready=1 and no hazards (capture and handoff in the same cycle).
- Wakeup: wb_we for a blocking register at edge N → id_valid high in cycle N+1.
- Stall: outputs and read_reg1/2 hold stable while id_valid && !id_ready, and while hazard.
- Reset asserted mid-stall or mid-handshake: state cleared at that edge, in-flight instruction lost, no scoreboard bit survives.

## Configuration
- RISC_WAW_CHECK_EN defined:
  - Hazard also includes id_we && pending[id_wreg].
  - An instruction never issues while an older write to its destination is outstanding.
- Undefined:
  - Hazard covers sources only; WAW ordering is left to the writeback path.

## Test plan
- Reset → if_ready=1, id_valid=0, all decoded outputs 0, pending=0.
- addi 0x2C7F at PC 0x0010 with id_ready=1:
  - Next cycle: read_reg1=0, id_wreg=3, id_we=1, id_imm=0xFFFF, id_pc=0x0010, id_valid=1.
- lui 0x73FF → id_imm=0xFFC0, id_wreg=4, read_reg1=read_reg2=0.
- Load-use stall:
  - lw 0xA400 handed off, then add 0x0880 captured → id_valid=0 while pending[1]=1.
  - wb_we=1, wb_reg=1 → id_valid=1 next cycle with read_reg1=1, read_reg2=0.
- Back-to-back stream of 4 independent instructions with id_ready=1 → one handoff per cycle, if_ready stays 1.
- ex_flush asserted with full=1 and if_valid=1 → next cycle full=0, id_valid=0, pending unchanged; the flushed add never sets pending[2].
- With RISC_WAW_CHECK_EN:
  - addi r1 then lw r1 → second instruction stalls until wb_reg=1.
  - Without the macro, the second instruction issues immediately.
